video_sync_mixer: RTL and testbench



---
 rtl/video_pkg.sv | 53 +++++
 rtl/sync_polarity_fix.sv | 52 +++++
 rtl/video_sync_mixer.sv | 157 +++++++++++++++
 tb/tb_video_sync_mixer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the arcade video front end:
// packed-RGB formats and the per-channel colour expansion.
package video_pkg;

  localparam int DW_RGB222 = 6;
  localparam int DW_RGB332 = 8;
  localparam int DW_RGB333 = 9;
  localparam int DW_RGB444 = 12;
  localparam int DW_RGB666 = 18;
  localparam int DW_RGB888 = 24;

  function automatic bit fmt_known(int dw);
    return dw inside {DW_RGB222, DW_RGB332, DW_RGB333,
                      DW_RGB444, DW_RGB666, DW_RGB888};
  endfunction

  function automatic int fld_r(int dw);
    case (dw)
      DW_RGB222:            return 2;
      DW_RGB332, DW_RGB333: return 3;
      DW_RGB444:            return 4;
      DW_RGB666:            return 6;
      default:              return 8;
    endcase
  endfunction

  function automatic int fld_g(int dw);
    return fld_r(dw);
  endfunction

  function automatic int fld_b(int dw);
    case (dw)
      DW_RGB222, DW_RGB332: return 2;
      DW_RGB333:            return 3;
      DW_RGB444:            return 4;
      DW_RGB666:            return 6;
      default:              return 8;
    endcase
  endfunction

  // MSB-first replication of a w-bit field, then 4-bit depth for non-888
  function automatic logic [7:0] expand_color(int dw, int w,
                                              logic [7:0] f);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < 8; i++)
      x[7-i] = f[w-1-(i%w)];
    if (dw != DW_RGB888)
      x = {x[7:4], x[7:4]};
    return x;
  endfunction

endpackage

// File: rtl/sync_polarity_fix.sv
// Learns sync polarity from the high/low phase lengths and
// presents the sync active-high (shorter phase high).
module sync_polarity_fix
  import video_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic CLK_VIDEO,
  input  logic reset,
  input  logic sync_in,
  output logic sync_out
);

  logic             s1_q;
  logic             s2_q;
  logic             pol_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] pos_q;
  logic [CNT_W-1:0] neg_q;

  always_comb begin
    cnt_d = cnt_q;
    if (s1_q != s2_q)
      cnt_d = '0;
    else if (!(&cnt_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK_VIDEO or posedge reset) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      cnt_q <= '0;
      pos_q <= '0;
      neg_q <= '0;
      pol_q <= 1'b0;
    end else begin
      s1_q  <= sync_in;
      s2_q  <= s1_q;
      cnt_q <= cnt_d;
      if (!s2_q && s1_q)
        neg_q <= cnt_q;
      if (s2_q && !s1_q)
        pos_q <= cnt_q;
      pol_q <= (pos_q > neg_q);
    end
  end

  assign sync_out = sync_in ^ pol_q;

endmodule

// File: rtl/video_sync_mixer.sv
// Video front end: sync polarity fix, pixel strobe, colour
// expansion and registered VGA-style outputs.
module video_sync_mixer
  import video_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic          CLK_VIDEO,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic [DW-1:0] RGB_in,
  input  logic          HBlank,
  input  logic          VBlank,
  input  logic          HSync,
  input  logic          VSync,
  input  logic [2:0]    fx,
  output logic          CE_PIXEL,
  output logic [7:0]    VGA_R,
  output logic [7:0]    VGA_G,
  output logic [7:0]    VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_DE,
  output logic [1:0]    VGA_SL
);

  logic hs_fix;
  logic vs_fix;

  sync_polarity_fix #(.CNT_W(CNT_W)) u_hs_fix (
    .CLK_VIDEO (CLK_VIDEO),
    .reset     (reset),
    .sync_in   (HSync),
    .sync_out  (hs_fix)
  );

  sync_polarity_fix #(.CNT_W(CNT_W)) u_vs_fix (
    .CLK_VIDEO (CLK_VIDEO),
    .reset     (reset),
    .sync_in   (VSync),
    .sync_out  (vs_fix)
  );

  logic          old_ce_q;
  logic          ce_q;
  logic          strobe_d;
  logic          hs_q;
  logic          vs_q;
  logic          hbl_q;
  logic          vbl_q;
  logic [DW-1:0] rgb_q;

  assign strobe_d = ~old_ce_q & ce_pix;

  always_ff @(posedge CLK_VIDEO or posedge reset) begin
    if (reset) begin
      old_ce_q <= 1'b0;
      ce_q     <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      hbl_q    <= 1'b0;
      vbl_q    <= 1'b0;
      rgb_q    <= '0;
    end else begin
      old_ce_q <= ce_pix;
      ce_q     <= strobe_d;
      if (strobe_d) begin
        hs_q  <= hs_fix;
        rgb_q <= RGB_in;
        hbl_q <= HBlank;
        // frame-level state only moves at line edges
        if (!hs_q && hs_fix)
          vs_q <= vs_fix;
        if (hbl_q && !HBlank)
          vbl_q <= VBlank;
      end
    end
  end

  logic [7:0] col_r;
  logic [7:0] col_g;
  logic [7:0] col_b;

  localparam bit KNOWN = fmt_known(DW);

  if (KNOWN) begin : g_fmt
    localparam int RW = fld_r(DW);
    localparam int GW = fld_g(DW);
    localparam int BW = fld_b(DW);
    assign col_r = expand_color(DW, RW, 8'(rgb_q[DW-1 -: RW]));
    assign col_g = expand_color(DW, GW, 8'(rgb_q[BW +: GW]));
    assign col_b = expand_color(DW, BW, 8'(rgb_q[0 +: BW]));
  end else begin : g_raw
    logic [23:0] rgb24;
    if (DW >= 24) begin : g_trunc
      assign rgb24 = rgb_q[DW-1 -: 24];
    end else begin : g_pad
      assign rgb24 = {rgb_q, {(24-DW){1'b0}}};
    end
    assign col_r = rgb24[23:16];
    assign col_g = rgb24[15:8];
    assign col_b = rgb24[7:0];
  end

  logic       blank_d;
  logic [1:0] sl_d;
  logic       cep_q;
  logic [7:0] r_q;
  logic [7:0] g_q;
  logic [7:0] b_q;
  logic       vga_hs_q;
  logic       vga_vs_q;
  logic       de_q;
  logic [1:0] sl_q;

  always_comb begin
    blank_d = hbl_q | vbl_q;
    sl_d    = 2'd0;
    if (fx != 3'd0)
      sl_d = fx[1:0] - 2'd1;
  end

  always_ff @(posedge CLK_VIDEO or posedge reset) begin
    if (reset) begin
      cep_q    <= 1'b0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      vga_hs_q <= 1'b0;
      vga_vs_q <= 1'b0;
      de_q     <= 1'b0;
      sl_q     <= '0;
    end else begin
      cep_q <= ce_q;
      if (ce_q) begin
        r_q      <= blank_d ? 8'd0 : col_r;
        g_q      <= blank_d ? 8'd0 : col_g;
        b_q      <= blank_d ? 8'd0 : col_b;
        vga_hs_q <= hs_q;
        vga_vs_q <= vs_q;
        de_q     <= ~blank_d;
        sl_q     <= sl_d;
      end
    end
  end

  assign CE_PIXEL = cep_q;
  assign VGA_R    = r_q;
  assign VGA_G    = g_q;
  assign VGA_B    = b_q;
  assign VGA_HS   = vga_hs_q;
  assign VGA_VS   = vga_vs_q;
  assign VGA_DE   = de_q;
  assign VGA_SL   = sl_q;

endmodule

// File: tb/tb_video_sync_mixer.sv
// Random frames through DW=12 and DW=8 mixers, checked against
// a pixel-level model of the front end.
module tb_video_sync_mixer;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        ce_pix = 1'b0;
  logic        hb     = 1'b1;
  logic        vb     = 1'b1;
  logic        hs     = 1'b0;
  logic        vs     = 1'b0;
  logic [2:0]  fx     = 3'd0;
  logic [11:0] rgb12  = '0;
  logic [7:0]  rgb8   = '0;

  logic       ce_a, hs_a, vs_a, de_a;
  logic [7:0] r_a, g_a, b_a;
  logic [1:0] sl_a;
  logic       ce_b, hs_b, vs_b, de_b;
  logic [7:0] r_b, g_b, b_b;
  logic [1:0] sl_b;

  video_sync_mixer #(.DW(12), .CNT_W(16)) dut_a (
    .CLK_VIDEO (clk),    .reset (rst),     .ce_pix (ce_pix),
    .RGB_in    (rgb12),  .HBlank (hb),     .VBlank (vb),
    .HSync     (hs),     .VSync (vs),      .fx (fx),
    .CE_PIXEL  (ce_a),   .VGA_R (r_a),     .VGA_G (g_a),
    .VGA_B     (b_a),    .VGA_HS (hs_a),   .VGA_VS (vs_a),
    .VGA_DE    (de_a),   .VGA_SL (sl_a)
  );

  video_sync_mixer #(.DW(8), .CNT_W(16)) dut_b (
    .CLK_VIDEO (clk),    .reset (rst),     .ce_pix (ce_pix),
    .RGB_in    (rgb8),   .HBlank (hb),     .VBlank (vb),
    .HSync     (hs),     .VSync (vs),      .fx (fx),
    .CE_PIXEL  (ce_b),   .VGA_R (r_b),     .VGA_G (g_b),
    .VGA_B     (b_b),    .VGA_HS (hs_b),   .VGA_VS (vs_b),
    .VGA_DE    (de_b),   .VGA_SL (sl_b)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp,
               $time);
    end
  endtask

  function automatic logic [7:0] x4(input int n);
    return 8'(n * 17);
  endfunction

  // abstract stimulus state: "inside the sync pulse"
  bit hs_act   = 0;
  bit vs_act   = 0;
  bit sync_chk = 0;

  bit m_old, m_hs, m_vs, m_hbl, m_vbl, pend, blank;
  logic [7:0] p_r12, p_g12, p_b12, p_r8, p_g8, p_b8;
  logic [7:0] e_r12, e_g12, e_b12, e_r8, e_g8, e_b8;
  bit   p_de, p_hs, p_vs, e_de, e_hs, e_vs, e_ce;
  int   p_sl, e_sl;

  always @(posedge clk) begin
    if (rst) begin
      m_old = 0; m_hs = 0; m_vs = 0; m_hbl = 0; m_vbl = 0;
      pend = 0; e_ce = 0; e_de = 0; e_hs = 0; e_vs = 0; e_sl = 0;
      e_r12 = 0; e_g12 = 0; e_b12 = 0;
      e_r8 = 0; e_g8 = 0; e_b8 = 0;
    end else begin
      e_ce = pend;
      if (pend) begin
        e_r12 = p_r12; e_g12 = p_g12; e_b12 = p_b12;
        e_r8 = p_r8; e_g8 = p_g8; e_b8 = p_b8;
        e_de = p_de; e_hs = p_hs; e_vs = p_vs; e_sl = p_sl;
      end
      pend = 0;
      if (ce_pix && !m_old) begin
        if (!m_hs && hs_act) m_vs = vs_act;
        m_hs = hs_act;
        if (m_hbl && !hb) m_vbl = vb;
        m_hbl = hb;
        blank = m_hbl | m_vbl;
        p_r12 = blank ? 8'd0 : x4(int'(rgb12[11:8]));
        p_g12 = blank ? 8'd0 : x4(int'(rgb12[7:4]));
        p_b12 = blank ? 8'd0 : x4(int'(rgb12[3:0]));
        p_r8  = blank ? 8'd0 :
                x4(int'(rgb8[7:5]) * 2 + int'(rgb8[7:5]) / 4);
        p_g8  = blank ? 8'd0 :
                x4(int'(rgb8[4:2]) * 2 + int'(rgb8[4:2]) / 4);
        p_b8  = blank ? 8'd0 : x4(int'(rgb8[1:0]) * 5);
        p_de  = !blank;
        p_hs  = m_hs;
        p_vs  = m_vs;
        p_sl  = (fx == 0) ? 0 : (int'(fx) - 1) % 4;
        pend  = 1;
      end
      m_old = ce_pix;
    end
    #1;
    chk("ce_12", ce_a, e_ce);
    chk("ce_8", ce_b, e_ce);
    chk("r_12", r_a, e_r12);
    chk("g_12", g_a, e_g12);
    chk("b_12", b_a, e_b12);
    chk("r_8", r_b, e_r8);
    chk("g_8", g_b, e_g8);
    chk("b_8", b_b, e_b8);
    chk("de_12", de_a, e_de);
    chk("de_8", de_b, e_de);
    chk("sl_12", sl_a, e_sl);
    chk("sl_8", sl_b, e_sl);
    if (rst || sync_chk) begin
      chk("hs_12", hs_a, e_hs);
      chk("vs_12", vs_a, e_vs);
      chk("hs_8", hs_b, e_hs);
      chk("vs_8", vs_b, e_vs);
    end
  end

  bit hs_low, vs_low;

  task automatic pix(input int f, input int l, input int p);
    int pos;
    int hi;
    int lo;
    pos = l * 64 + p;
    hi  = $urandom_range(1, 2);
    lo  = $urandom_range(1, 3);
    @(negedge clk);
    hs_act = (p < 4);
    vs_act = (pos >= 30) && (pos < 30 + 2 * 64);
    hs     = hs_low ? ~hs_act : hs_act;
    vs     = vs_low ? ~vs_act : vs_act;
    hb     = (p < 12);
    vb     = (pos >= 30) && (pos < 30 + 3 * 64);
    if (p == 0) fx = 3'($urandom_range(0, 7));
    rgb12  = (p == 21) ? 12'hF80 : 12'($urandom);
    rgb8   = (p == 20) ? 8'b101_011_10 : 8'($urandom);
    sync_chk = (f >= 2);
    ce_pix = 1'b1;
    for (int i = 1; i < hi; i++) @(negedge clk);
    @(negedge clk);
    ce_pix = 1'b0;
    for (int i = 1; i < lo; i++) @(negedge clk);
  endtask

  int n_ce;

  initial begin
    hs_low = 1'($urandom);
    vs_low = 1'($urandom);
    hs = hs_low;
    vs = vs_low;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    for (int f = 0; f < 4; f++)
      for (int l = 0; l < 12; l++)
        for (int p = 0; p < 64; p++)
          pix(f, l, p);

    // async reset during active video, ce_pix held high across it
    sync_chk = 0;
    @(negedge clk);
    ce_pix = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_de", de_a, 1'b0);
    chk("rst_async_rgb", {r_a, g_a, b_a}, 24'd0);
    chk("rst_async_misc", {ce_a, hs_a, vs_a, sl_a}, 5'd0);
    chk("rst_async_b", {r_b, g_b, b_b, de_b, ce_b}, 26'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_ce = 0;
    repeat (12) begin
      @(posedge clk);
      #2;
      if (ce_a) n_ce++;
    end
    chk("one_strobe", n_ce, 1);
    @(negedge clk);
    ce_pix = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
